// File: rtl/gf_ops_pkg.sv
// Shared op codes, FSM state encoding and decoded-select bundle for the GF/integer op sequencer.
package gf_ops_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_CLMUL = 3'd3;
  localparam logic [2:0] OP_SQR   = 3'd4;
  localparam logic [2:0] OP_GFMUL = 3'd5;
  localparam logic [2:0] OP_GFSQR = 3'd6;

  localparam int GF_MIN_GRADE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RED  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // dup: datapath b operand is a copy of a (squares)
  typedef struct packed {
    logic sum;
    logic exp;
    logic carry;
    logic two_pass;
    logic wide;
    logic dup;
    logic gf;
    logic legal;
  } dec_t;

endpackage

// File: rtl/gf_op_decode.sv
// Combinational op-code decode into datapath selects and sequencing flags.
module gf_op_decode
  import gf_ops_pkg::*;
(
  input  logic [2:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.legal = 1'b1;
    case (op_i)
      OP_ADD:   begin dec_o.sum = 1'b1; dec_o.carry = 1'b1; end
      OP_XOR:   dec_o.sum = 1'b1;
      OP_MUL:   begin dec_o.carry = 1'b1; dec_o.wide = 1'b1; end
      OP_CLMUL: dec_o.wide = 1'b1;
      OP_SQR:   begin dec_o.exp = 1'b1; dec_o.carry = 1'b1; dec_o.wide = 1'b1; dec_o.dup = 1'b1; end
      OP_GFMUL: begin dec_o.two_pass = 1'b1; dec_o.gf = 1'b1; end
      OP_GFSQR: begin dec_o.two_pass = 1'b1; dec_o.gf = 1'b1; dec_o.dup = 1'b1; end
      default:  dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/gf_op_sequencer.sv
// Command-driven sequencer for the GF/integer datapath: one op per handshake, GF ops as
// carry-less product followed by a reduction pass, result returned on a valid/ready port.
module gf_op_sequencer
  import gf_ops_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int W  = DATA_WIDTH,
  localparam int GW = $clog2(DATA_WIDTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic [W-1:0]    cmd_a_i,
  input  logic [W-1:0]    cmd_b_i,
  input  logic [W:0]      cmd_poly_i,
  input  logic [GW-1:0]   cmd_grade_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [2*W-1:0]  rsp_data_o,
  output logic            rsp_err_o,
  output logic            dp_sum_funct_o,
  output logic            dp_exp_funct_o,
  output logic            dp_red_funct_o,
  output logic            dp_carry_option_o,
  output logic [W-1:0]    dp_a_o,
  output logic [W-1:0]    dp_b_o,
  output logic [W:0]      dp_polyn_red_in_o,
  output logic [2*W-1:0]  dp_reduc_in_o,
  output logic [GW-1:0]   dp_polyn_grade_o,
  input  logic [W-1:0]    dp_out_i,
  input  logic [2*W-1:0]  dp_mult_out_i
);

  dec_t dec;

  gf_op_decode u_dec (
    .op_i  (cmd_op_i),
    .dec_o (dec)
  );

  state_e          state_q;
  logic            cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic [2*W-1:0]  rsp_data_q;
  logic            sum_q, exp_q, red_q, carry_q, two_pass_q, wide_q;
  logic [W-1:0]    a_q, b_q;
  logic [W:0]      poly_q;
  logic [2*W-1:0]  reduc_q;
  logic [GW-1:0]   grade_q;

  logic [W:0]      poly_d;
  logic [2*W-1:0]  narrow_d;
  logic            grade_bad, opnd_bad, cmd_bad;

  // The leading coefficient is implied by the degree, so it is always set.
  assign poly_d   = cmd_poly_i | ((W+1)'(1) << cmd_grade_i);
  assign narrow_d = {{W{1'b0}}, dp_out_i};

  assign grade_bad = (cmd_grade_i < GW'(GF_MIN_GRADE)) || (cmd_grade_i > GW'(W));
  assign opnd_bad  = ((cmd_a_i >> cmd_grade_i) != '0) ||
                     (!dec.dup && ((cmd_b_i >> cmd_grade_i) != '0));
  assign cmd_bad   = !dec.legal || (dec.gf && (grade_bad || opnd_bad));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      sum_q       <= 1'b0;
      exp_q       <= 1'b0;
      red_q       <= 1'b0;
      carry_q     <= 1'b0;
      two_pass_q  <= 1'b0;
      wide_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      poly_q      <= '0;
      reduc_q     <= '0;
      grade_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid_i) begin
          cmd_ready_q <= 1'b0;
          if (cmd_bad) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            state_q    <= ST_EXEC;
            sum_q      <= dec.sum;
            exp_q      <= dec.exp;
            carry_q    <= dec.carry;
            two_pass_q <= dec.two_pass;
            wide_q     <= dec.wide;
            a_q        <= cmd_a_i;
            b_q        <= dec.dup ? cmd_a_i : cmd_b_i;
            poly_q     <= dec.gf ? poly_d : '0;
            grade_q    <= dec.gf ? cmd_grade_i : '0;
          end
        end
        ST_EXEC: begin
          sum_q   <= 1'b0;
          exp_q   <= 1'b0;
          carry_q <= 1'b0;
          if (two_pass_q) begin
            state_q <= ST_RED;
            red_q   <= 1'b1;
            reduc_q <= dp_mult_out_i;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= wide_q ? dp_mult_out_i : narrow_d;
            a_q         <= '0;
            b_q         <= '0;
          end
        end
        ST_RED: begin
          state_q     <= ST_RESP;
          red_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= narrow_d;
          a_q         <= '0;
          b_q         <= '0;
          poly_q      <= '0;
          grade_q     <= '0;
          reduc_q     <= '0;
        end
        ST_RESP: if (rsp_ready_i) begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          cmd_ready_q <= 1'b1;
          two_pass_q  <= 1'b0;
          wide_q      <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o       = cmd_ready_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_err_o         = rsp_err_q;
  assign rsp_data_o        = rsp_data_q;
  assign dp_sum_funct_o    = sum_q;
  assign dp_exp_funct_o    = exp_q;
  assign dp_red_funct_o    = red_q;
  assign dp_carry_option_o = carry_q;
  assign dp_a_o            = a_q;
  assign dp_b_o            = b_q;
  assign dp_polyn_red_in_o = poly_q;
  assign dp_reduc_in_o     = reduc_q;
  assign dp_polyn_grade_o  = grade_q;

endmodule

// File: tb/tb_gf_op_sequencer.sv
// Scoreboard bench for gf_op_sequencer at W=8 with a behavioural GF/integer datapath attached.
module tb_gf_op_sequencer;

  localparam int W  = 8;
  localparam int GW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready;
  logic [2:0]      cmd_op;
  logic [W-1:0]    cmd_a, cmd_b;
  logic [W:0]      cmd_poly;
  logic [GW-1:0]   cmd_grade;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [2*W-1:0]  rsp_data;
  logic            dp_sum, dp_exp, dp_red, dp_carry;
  logic [W-1:0]    dp_a, dp_b, dp_out;
  logic [W:0]      dp_poly;
  logic [2*W-1:0]  dp_reduc_in, dp_mult_out;
  logic [GW-1:0]   dp_grade;

  always #5 clk = ~clk;

  gf_op_sequencer #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_poly_i(cmd_poly), .cmd_grade_i(cmd_grade),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .dp_sum_funct_o(dp_sum), .dp_exp_funct_o(dp_exp), .dp_red_funct_o(dp_red),
    .dp_carry_option_o(dp_carry), .dp_a_o(dp_a), .dp_b_o(dp_b),
    .dp_polyn_red_in_o(dp_poly), .dp_reduc_in_o(dp_reduc_in), .dp_polyn_grade_o(dp_grade),
    .dp_out_i(dp_out), .dp_mult_out_i(dp_mult_out)
  );

  // behavioural stand-in for the attached datapath
  function automatic logic [2*W-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] r = '0;
    for (int i = 0; i < W; i++) if (y[i]) r ^= ({{W{1'b0}}, x} << i);
    return r;
  endfunction

  function automatic logic [W-1:0] reduce(input logic [2*W-1:0] x, input logic [W:0] p,
                                         input logic [GW-1:0] g);
    logic [2*W-1:0] r = x;
    for (int i = 2*W-1; i >= 0; i--)
      if (i >= int'(g) && r[i]) r ^= ({{(W-1){1'b0}}, p} << (i - int'(g)));
    return r[W-1:0];
  endfunction

  always_comb begin
    dp_out      = '0;
    dp_mult_out = '0;
    if (dp_red)      dp_out = reduce(dp_reduc_in, dp_poly, dp_grade);
    else if (dp_sum) dp_out = dp_carry ? dp_a + dp_b : dp_a ^ dp_b;
    if (dp_exp)      dp_mult_out = dp_carry ? {{W{1'b0}}, dp_a} * {{W{1'b0}}, dp_a} : clmul(dp_a, dp_a);
    else             dp_mult_out = dp_carry ? {{W{1'b0}}, dp_a} * {{W{1'b0}}, dp_b} : clmul(dp_a, dp_b);
  end

  typedef struct {
    logic [2*W-1:0] d;
    logic           e;
    int             lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat_cnt = 0;
  bit   seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // cycles since the accepting edge
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) lat_cnt = 0;
    else                        lat_cnt = lat_cnt + 1;
  end

  // monitor: pops the scoreboard on each response handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else                  chk("rsp_latency", 32'(lat_cnt + 1), 32'(sb_q[0].lat));
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_err", 32'(rsp_err), 32'(e.e));
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // returns one step after the accepting edge (EXEC cycle for good ops)
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] poly, input logic [3:0] grade,
                       input logic [15:0] ed, input logic ee, input int lat, input bit push);
    int n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_poly = poly; cmd_grade = grade;
    cmd_valid = 1'b1;
    if (push) sb_q.push_back('{d: ed, e: ee, lat: lat});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && n < 30) begin step(); n++; end
    if (sb_q.size() != 0 || !cmd_ready) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_poly = '0; cmd_grade = '0; rsp_ready = 1'b1;
    repeat (3) step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_selects",   32'({dp_sum, dp_exp, dp_red, dp_carry}), 32'd0);
    chk("rst_operands",  32'({dp_a, dp_b, dp_reduc_in}), 32'd0);
    rst_n = 1'b1;
    step();

    issue(3'd0, 8'hF0, 8'h20, 9'h0, 4'd0, 16'h0010, 1'b0, 2, 1'b1);
    chk("add_exec_sel", 32'({dp_sum, dp_exp, dp_red, dp_carry}), 32'b1001);
    drain();
    issue(3'd1, 8'h5A, 8'hFF, 9'h0, 4'd0, 16'h00A5, 1'b0, 2, 1'b1); drain();
    issue(3'd2, 8'h03, 8'h03, 9'h0, 4'd0, 16'h0009, 1'b0, 2, 1'b1); drain();
    issue(3'd3, 8'h03, 8'h03, 9'h0, 4'd0, 16'h0005, 1'b0, 2, 1'b1); drain();
    issue(3'd2, 8'hFF, 8'hFF, 9'h0, 4'd0, 16'hFE01, 1'b0, 2, 1'b1); drain();
    issue(3'd0, 8'hFF, 8'h01, 9'h0, 4'd0, 16'h0000, 1'b0, 2, 1'b1); drain();
    issue(3'd4, 8'h0F, 8'h55, 9'h0, 4'd0, 16'h00E1, 1'b0, 2, 1'b1);
    chk("sqr_exec_sel", 32'({dp_sum, dp_exp, dp_red, dp_carry}), 32'b0101);
    drain();

    issue(3'd5, 8'h57, 8'h83, 9'h11B, 4'd8, 16'h00C1, 1'b0, 3, 1'b1);
    chk("gf_exec_sel", 32'({dp_sum, dp_exp, dp_red, dp_carry, dp_a, dp_b}), 32'h0005783);
    step();
    chk("gf_red_sel", 32'({dp_sum, dp_exp, dp_red, dp_carry}), 32'b0010);
    chk("gf_reduc_in", 32'(dp_reduc_in), 32'h2B79);
    chk("gf_poly", 32'({dp_poly, dp_grade}), 32'({9'h11B, 4'd8}));
    drain();
    issue(3'd6, 8'h80, 8'h00, 9'h11B, 4'd8, 16'h009A, 1'b0, 3, 1'b1); drain();
    // leading coefficient left off the supplied polynomial
    issue(3'd5, 8'h08, 8'h02, 9'h003, 4'd4, 16'h0003, 1'b0, 3, 1'b1); drain();

    issue(3'd5, 8'h01, 8'h01, 9'h003, 4'd1, 16'h0000, 1'b1, 1, 1'b1);
    chk("err_grade1_sel", 32'({dp_sum, dp_exp, dp_red, dp_carry}), 32'd0);
    drain();
    issue(3'd7, 8'h12, 8'h34, 9'h0, 4'd0, 16'h0000, 1'b1, 1, 1'b1);
    chk("err_op7_sel", 32'({dp_sum, dp_exp, dp_red, dp_carry}), 32'd0);
    drain();
    issue(3'd5, 8'h10, 8'h01, 9'h013, 4'd4, 16'h0000, 1'b1, 1, 1'b1); drain();
    issue(3'd6, 8'h01, 8'hFF, 9'h011, 4'd9, 16'h0000, 1'b1, 1, 1'b1); drain();

    // consumer stall
    rsp_ready = 1'b0;
    issue(3'd1, 8'h3C, 8'h0F, 9'h0, 4'd0, 16'h0033, 1'b0, 2, 1'b1);
    begin
      int n = 0;
      while (!rsp_valid && n < 10) begin step(); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data",  32'(rsp_data), 32'h0033);
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    drain();

    // reset while a GFSQR is in its reduction pass; no response may follow
    issue(3'd6, 8'h80, 8'h00, 9'h11B, 4'd8, 16'h0000, 1'b0, 0, 1'b0);
    step();
    chk("rstmid_in_red", 32'(dp_red), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstmid_red_clr",   32'(dp_red), 32'd0);
    rst_n = 1'b1;
    repeat (6) step();
    issue(3'd0, 8'h11, 8'h22, 9'h0, 4'd0, 16'h0033, 1'b0, 2, 1'b1); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
